// File: rtl/hamm_secded_codec.sv
// Hamming SEC-DED codec, two-stage pipeline with valid/ready handshake.
// Encode packs DATA_W data bits into an extended Hamming codeword; decode
// corrects single-bit errors, flags double-bit errors and keeps saturating
// error counters.
module hamm_secded_codec #(
  parameter int DATA_W = 8,
  parameter int P_W    = 4,
  parameter int CW_W   = DATA_W + P_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_data,
  output logic              out_err_single,
  output logic              out_err_double,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  input  logic              cnt_clr
);

  localparam int unsigned CW_U = CW_W;
  localparam int unsigned PW_U = P_W;
  localparam int unsigned DW_U = DATA_W;

  // Non-power-of-two positions carry data; powers of two carry Hamming parity.
  function automatic logic is_data_pos(input int unsigned p);
    return (p & (p - 1)) != 0;
  endfunction

  function automatic logic [CW_W-1:0] place_data(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] w;
    int unsigned     j;
    w = '0;
    j = 0;
    for (int unsigned p = 1; p < CW_U; p++) begin
      if (is_data_pos(p) && j < DW_U) begin
        w[p] = d[j];
        j++;
      end
    end
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] w);
    logic [DATA_W-1:0] d;
    int unsigned       j;
    d = '0;
    j = 0;
    for (int unsigned p = 1; p < CW_U; p++) begin
      if (is_data_pos(p) && j < DW_U) begin
        d[j] = w[p];
        j++;
      end
    end
    return d;
  endfunction

  // Syndrome bit k is the XOR of every position whose index has bit k set.
  function automatic logic [P_W-1:0] syndrome(input logic [CW_W-1:0] w);
    logic [P_W-1:0] s;
    s = '0;
    for (int unsigned p = 1; p < CW_U; p++) begin
      if (w[p]) s = s ^ P_W'(p);
    end
    return s;
  endfunction

  logic              adv;
  logic              s1_valid_q;
  logic              s1_mode_q;
  logic [CW_W-1:0]   s1_word_q;
  logic [P_W-1:0]    s1_syn_q;
  logic              s1_par_q;
  logic [CW_W-1:0]   s1_word_d;
  logic [P_W-1:0]    s1_syn_d;
  logic              s1_par_d;

  logic              out_valid_q;
  logic [CW_W-1:0]   out_data_q;
  logic              err_single_q;
  logic              err_double_q;
  logic [CW_W-1:0]   out_data_d;
  logic              err_single_d;
  logic              err_double_d;
  logic [CW_W-1:0]   fixed;
  logic              hit;

  logic [CNT_W-1:0]  corr_q;
  logic [CNT_W-1:0]  uncorr_q;
  logic [CNT_W-1:0]  corr_d;
  logic [CNT_W-1:0]  uncorr_d;
  logic              fire;

  // Whole pipeline advances unless a valid output is being held back.
  assign adv       = !out_valid_q | out_ready;
  assign in_ready  = adv;
  assign fire      = out_valid_q & out_ready;

  // Stage 1 inputs: in encode mode the data is placed with zero parity bits,
  // so the syndrome of that word is exactly the parity pattern to insert.
  always_comb begin
    s1_word_d = mode ? in_data : place_data(in_data[DATA_W-1:0]);
    s1_syn_d  = syndrome(s1_word_d);
    s1_par_d  = ^s1_word_d;
  end

  // Stage 1 register: raw word, syndrome and overall parity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_word_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode;
        s1_word_q <= s1_word_d;
        s1_syn_q  <= s1_syn_d;
        s1_par_q  <= s1_par_d;
      end
    end
  end

  // Stage 2 logic: finish encoding, or correct/classify and extract data.
  always_comb begin
    fixed        = s1_word_q;
    hit          = 1'b0;
    out_data_d   = '0;
    err_single_d = 1'b0;
    err_double_d = 1'b0;
    if (!s1_mode_q) begin
      for (int unsigned k = 0; k < PW_U; k++) begin
        if ((32'd1 << k) < CW_U) fixed[32'd1 << k] = s1_syn_q[k];
      end
      fixed[0]   = ^fixed[CW_W-1:1];
      out_data_d = fixed;
    end else begin
      for (int unsigned p = 1; p < CW_U; p++) begin
        if (s1_syn_q == P_W'(p)) begin
          hit = 1'b1;
          if (s1_par_q) fixed[p] = ~fixed[p];
        end
      end
      err_single_d = s1_par_q & ((s1_syn_q == '0) | hit);
      err_double_d = (s1_syn_q != '0) & ~(s1_par_q & hit);
      out_data_d   = CW_W'(extract_data(fixed));
    end
  end

  // Stage 2 register: output beat and flags, held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      err_single_q <= 1'b0;
      err_double_q <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q   <= out_data_d;
        err_single_q <= err_single_d;
        err_double_q <= err_double_d;
      end
    end
  end

  // Counter next state: clear wins, otherwise saturating count at handshake.
  always_comb begin
    corr_d   = corr_q;
    uncorr_d = uncorr_q;
    if (cnt_clr) begin
      corr_d   = '0;
      uncorr_d = '0;
    end else if (fire) begin
      if (err_single_q && !(&corr_q))   corr_d   = corr_q + 1'b1;
      if (err_double_q && !(&uncorr_q)) uncorr_d = uncorr_q + 1'b1;
    end
  end

  // Error counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_q   <= '0;
      uncorr_q <= '0;
    end else begin
      corr_q   <= corr_d;
      uncorr_q <= uncorr_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_err_single = err_single_q;
  assign out_err_double = err_double_q;
  assign corr_cnt       = corr_q;
  assign uncorr_cnt     = uncorr_q;

endmodule

// File: tb/tb_hamm_secded_codec.sv
// Bench for hamm_secded_codec: behavioural SEC-DED model with a queue-based
// scoreboard, directed cases with literal expectations, then random traffic.
module tb_hamm_secded_codec;

  localparam int DATA_W = 8;
  localparam int P_W    = 4;
  localparam int CW_W   = 13;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CW_W-1:0]   out_data;
  logic              out_err_single;
  logic              out_err_double;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;
  logic              cnt_clr = 1'b0;

  always #5 clk = ~clk;

  hamm_secded_codec #(.DATA_W(DATA_W), .P_W(P_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_err_single(out_err_single), .out_err_double(out_err_double),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .cnt_clr(cnt_clr)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int data;
    bit s;
    bit d;
    bit dec;
    int advs;
  } exp_t;

  // Position of data bit j: j-th non-power-of-two index starting at 1.
  function automatic int dpos(input int j);
    int c = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (c == j) return p;
        c++;
      end
    end
    return 0;
  endfunction

  // Classic syndrome: XOR of the indices of all set bits (bit0 excluded).
  function automatic int m_syn(input int w);
    int s = 0;
    for (int p = 1; p < CW_W; p++) if (((w >> p) & 1) != 0) s = s ^ p;
    return s;
  endfunction

  function automatic int m_enc(input int d);
    int cw = 0;
    int s;
    for (int j = 0; j < DATA_W; j++) if (((d >> j) & 1) != 0) cw = cw | (1 << dpos(j));
    s = m_syn(cw);
    for (int k = 0; k < P_W; k++) if (((s >> k) & 1) != 0) cw = cw | (1 << (1 << k));
    if (($countones(cw) % 2) != 0) cw = cw | 1;
    return cw;
  endfunction

  function automatic int m_extract(input int w);
    int d = 0;
    for (int j = 0; j < DATA_W; j++) if (((w >> dpos(j)) & 1) != 0) d = d | (1 << j);
    return d;
  endfunction

  function automatic exp_t m_model(input bit m, input int w);
    exp_t e;
    int   s;
    int   par;
    e.s = 0; e.d = 0; e.dec = m; e.advs = 0;
    if (!m) begin
      e.data = m_enc(w & ((1 << DATA_W) - 1));
    end else begin
      s   = m_syn(w);
      par = $countones(w) % 2;
      if (par == 1 && s == 0) e.s = 1;
      else if (par == 1 && s < CW_W) begin
        w   = w ^ (1 << s);
        e.s = 1;
      end else if (s != 0) e.d = 1;
      e.data = m_extract(w);
    end
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t q[$];
  int   m_corr = 0;
  int   m_unc  = 0;
  bit   exp_v;
  bit   fire;
  bit   adv;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      q.delete();
      m_corr = 0;
      m_unc  = 0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_corr", 32'(corr_cnt), 0);
      chk("rst_uncorr", 32'(uncorr_cnt), 0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].advs >= 1);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      chk("in_ready", 32'(in_ready), 32'(!exp_v || out_ready));
      if (exp_v) begin
        chk("out_data", 32'(out_data), q[0].data);
        chk("err_single", 32'(out_err_single), 32'(q[0].s));
        chk("err_double", 32'(out_err_double), 32'(q[0].d));
      end
      chk("corr_cnt", 32'(corr_cnt), m_corr);
      chk("uncorr_cnt", 32'(uncorr_cnt), m_unc);
      // Advance the model across the coming clock edge.
      adv  = !exp_v || out_ready;
      fire = exp_v && out_ready;
      if (cnt_clr) begin
        m_corr = 0;
        m_unc  = 0;
      end else if (fire && q[0].dec) begin
        if (q[0].s && m_corr < CMAX) m_corr++;
        if (q[0].d && m_unc < CMAX)  m_unc++;
      end
      if (fire) void'(q.pop_front());
      if (adv) begin
        for (int i = 0; i < q.size(); i++) q[i].advs = q[i].advs + 1;
        if (in_valid) q.push_back(m_model(mode, int'(in_data)));
      end
    end
  end

  // ---------------- directed helpers ----------------
  // One beat through an empty pipeline with out_ready high; checks latency.
  task automatic run1(input bit m, input int w, input int exp_data,
                      input bit es, input bit ed, input bit clr_at_out);
    @(negedge clk);
    mode = m; in_data = CW_W'(w); in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #3 chk("lat_not_yet", 32'(out_valid), 0);
    @(negedge clk);
    if (clr_at_out) cnt_clr = 1'b1;
    #3;
    chk("lat_valid", 32'(out_valid), 1);
    chk("dir_data", 32'(out_data), exp_data);
    chk("dir_single", 32'(out_err_single), 32'(es));
    chk("dir_double", 32'(out_err_double), 32'(ed));
    @(negedge clk);
    cnt_clr = 1'b0;
    #3;
  endtask

  function automatic int rand_word();
    int w;
    int a;
    int b;
    w = m_enc(int'($urandom_range(0, 255)));
    a = int'($urandom_range(0, CW_W - 1));
    b = (a + 1 + int'($urandom_range(0, CW_W - 2))) % CW_W;
    case ($urandom_range(0, 4))
      0: ;
      1: w = w ^ (1 << a);
      2: w = w ^ (1 << a) ^ (1 << b);
      3: w = w ^ (1 << a) ^ (1 << b) ^ (1 << int'($urandom_range(0, CW_W - 1)));
      default: w = int'($urandom_range(0, (1 << CW_W) - 1));
    endcase
    return w;
  endfunction

  logic [CW_W-1:0] beats [4];
  logic [CW_W-1:0] held;
  exp_t            pin;
  int              idx;

  initial begin
    // Pin the model to hand-computed values.
    chk("pin_enc_A5", m_enc(8'hA5), 32'h144E);
    pin = m_model(1'b1, 32'h140E);
    chk("pin_dec_140E", pin.data, 32'hA5);
    chk("pin_dec_140E_s", 32'(pin.s), 1);
    pin = m_model(1'b1, 32'h1406);
    chk("pin_dec_1406", pin.data, 32'hA0);
    chk("pin_dec_1406_d", 32'(pin.d), 1);

    #1;
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_flags", 32'({out_err_single, out_err_double}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run1(1'b0, 32'h0A5, 32'h144E, 1'b0, 1'b0, 1'b0);
    run1(1'b1, 32'h144E, 32'h0A5, 1'b0, 1'b0, 1'b0);
    run1(1'b1, 32'h140E, 32'h0A5, 1'b1, 1'b0, 1'b0);
    chk("corr_after_bit6", 32'(corr_cnt), 1);
    run1(1'b1, 32'h144F, 32'h0A5, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 32'h1406, 32'h0A0, 1'b0, 1'b1, 1'b0);
    chk("uncorr_after_double", 32'(uncorr_cnt), 1);

    // Stall: out_ready low for 5 cycles while streaming 4 beats.
    beats[0] = 13'h0A5; beats[1] = 13'h03C; beats[2] = 13'h0FF; beats[3] = 13'h000;
    idx = 0;
    held = '0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      mode = 1'b0;
      if (idx < 4) begin
        in_valid = 1'b1;
        in_data  = beats[idx];
      end else in_valid = 1'b0;
      #1;
      if (c == 2) held = out_data;
      if (c == 3) chk("stall_in_ready_low", 32'(in_ready), 0);
      if (c == 4) begin
        chk("stall_hold", 32'(out_data), 32'(held));
        chk("stall_data", 32'(out_data), 32'h144E);
      end
      if (c == 5) chk("stall_in_ready_comb", 32'(in_ready), 1);
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    chk("stall_all_sent", idx, 4);

    // Saturation of the 2-bit correctable counter.
    repeat (5) run1(1'b1, 32'h140E, 32'h0A5, 1'b1, 1'b0, 1'b0);
    chk("corr_saturated", 32'(corr_cnt), 3);
    // Clear wins over a same-cycle error beat.
    run1(1'b1, 32'h140E, 32'h0A5, 1'b1, 1'b0, 1'b1);
    chk("clr_corr", 32'(corr_cnt), 0);
    chk("clr_uncorr", 32'(uncorr_cnt), 0);

    // Random traffic with random backpressure and mode switching.
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      mode      = $urandom_range(0, 1) != 0;
      in_data   = mode ? CW_W'(rand_word()) : CW_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 39) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (4) @(negedge clk);
    #3 chk("drain_empty", q.size(), 0);

    // Async reset with two beats in flight.
    @(negedge clk);
    mode = 1'b1; in_data = 13'h140E; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_data = 13'h1406;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_reset_valid", 32'(out_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_valid", 32'(out_valid), 0);
    chk("mid_reset_corr", 32'(corr_cnt), 0);
    chk("mid_reset_uncorr", 32'(uncorr_cnt), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run1(1'b0, 32'h0A5, 32'h144E, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
